// File: rtl/divider_int.sv
// Fully pipelined signed integer divider: one restoring step per stage, OPP_W+2 cycle latency.
// Truncating division with flagged handling of divide-by-zero and the most-negative / -1 overflow.
module divider_int #(
   parameter int OPP_W = 8
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             in_valid,
   input  logic [OPP_W-1:0] dividend,
   input  logic [OPP_W-1:0] divisor,
   output logic             out_valid,
   output logic [OPP_W-1:0] quotient,
   output logic [OPP_W-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   logic [OPP_W:0]   r_vld;
   logic [OPP_W:0]   r_sa;
   logic [OPP_W:0]   r_sb;
   logic [OPP_W:0]   r_dz;
   logic [OPP_W:0]   r_ov;
   logic [OPP_W-1:0] r_aq   [0:OPP_W];
   logic [OPP_W-1:0] r_rem  [0:OPP_W];
   logic [OPP_W-1:0] r_bmag [0:OPP_W-1];

   logic             r_fv;
   logic [OPP_W-1:0] r_fq;
   logic [OPP_W-1:0] r_fr;
   logic             r_fdz;
   logic             r_fov;

   logic [OPP_W-1:0] w_amag;
   logic [OPP_W-1:0] w_bmag;
   logic             w_dz;
   logic             w_ov;
   logic [OPP_W:0]   w_shift [1:OPP_W];
   logic [OPP_W:0]   w_diff  [1:OPP_W];
   logic             w_qneg;
   logic [OPP_W-1:0] w_q;
   logic [OPP_W-1:0] w_r;

   // Unsigned magnitudes: -2^(OPP_W-1) maps to 2^(OPP_W-1), which fits OPP_W unsigned bits.
   always_comb begin
      w_amag = dividend[OPP_W-1] ? (~dividend + 1'b1) : dividend;
      w_bmag = divisor[OPP_W-1]  ? (~divisor + 1'b1)  : divisor;
      w_dz   = (divisor == '0);
      w_ov   = (dividend == {1'b1, {(OPP_W-1){1'b0}}}) && (divisor == '1);
   end

   // Trial subtraction per stage; the extra MSB of the difference is the borrow.
   always_comb begin
      for (int k = 1; k <= OPP_W; k++) begin
         w_shift[k] = {r_rem[k-1], r_aq[k-1][OPP_W-1]};
         w_diff[k]  = w_shift[k] - {1'b0, r_bmag[k-1]};
      end
   end

   always_comb begin
      w_qneg = r_sa[OPP_W] ^ r_sb[OPP_W];
      w_q    = r_aq[OPP_W];
      if (r_dz[OPP_W])
         w_q = '1;
      else if (w_qneg)
         w_q = ~r_aq[OPP_W] + 1'b1;
      w_r = r_sa[OPP_W] ? (~r_rem[OPP_W] + 1'b1) : r_rem[OPP_W];
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_vld <= '0;
         r_sa  <= '0;
         r_sb  <= '0;
         r_dz  <= '0;
         r_ov  <= '0;
         for (int k = 0; k <= OPP_W; k++) begin
            r_aq[k]  <= '0;
            r_rem[k] <= '0;
         end
         for (int k = 0; k < OPP_W; k++)
            r_bmag[k] <= '0;
      end else begin
         r_vld[0]  <= in_valid;
         r_sa[0]   <= dividend[OPP_W-1];
         r_sb[0]   <= divisor[OPP_W-1];
         r_dz[0]   <= w_dz;
         r_ov[0]   <= w_ov;
         r_aq[0]   <= w_amag;
         r_rem[0]  <= '0;
         r_bmag[0] <= w_bmag;
         // The dividend shifts out of r_aq MSB-first while quotient bits fill in at the LSB.
         for (int k = 1; k <= OPP_W; k++) begin
            r_vld[k] <= r_vld[k-1];
            r_sa[k]  <= r_sa[k-1];
            r_sb[k]  <= r_sb[k-1];
            r_dz[k]  <= r_dz[k-1];
            r_ov[k]  <= r_ov[k-1];
            if (!w_diff[k][OPP_W]) begin
               r_rem[k] <= w_diff[k][OPP_W-1:0];
               r_aq[k]  <= {r_aq[k-1][OPP_W-2:0], 1'b1};
            end else begin
               r_rem[k] <= w_shift[k][OPP_W-1:0];
               r_aq[k]  <= {r_aq[k-1][OPP_W-2:0], 1'b0};
            end
         end
         for (int k = 1; k < OPP_W; k++)
            r_bmag[k] <= r_bmag[k-1];
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_fv  <= 1'b0;
         r_fq  <= '0;
         r_fr  <= '0;
         r_fdz <= 1'b0;
         r_fov <= 1'b0;
      end else begin
         r_fv  <= r_vld[OPP_W];
         r_fq  <= w_q;
         r_fr  <= w_r;
         r_fdz <= r_dz[OPP_W];
         r_fov <= r_ov[OPP_W];
      end
   end

   // Results only update on a valid slot, so bubbles leave the last result visible.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         out_valid <= r_fv;
         if (r_fv) begin
            quotient    <= r_fq;
            remainder   <= r_fr;
            div_by_zero <= r_fdz;
            overflow    <= r_fov;
         end
      end
   end

endmodule

// File: tb/tb_divider_int.sv
// Scoreboarded bench for divider_int: driver pushes expected results from an integer-arithmetic
// reference, a negedge monitor pops and compares values and exact arrival edge.
module tb_divider_int;

   localparam int W   = 8;
   localparam int LAT = W + 2;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      bit           dz;
      bit           ov;
      int           edgeN;
      int           a;
      int           b;
   } expT;

   logic         clk;
   logic         aresetn;
   logic         inValid;
   logic [W-1:0] dividendIn;
   logic [W-1:0] divisorIn;
   logic         outValid;
   logic [W-1:0] quotientOut;
   logic [W-1:0] remainderOut;
   logic         divByZero;
   logic         overflowOut;

   int  nChecks = 0;
   int  nPass   = 0;
   int  cyc     = 0;
   expT sb[$];

   divider_int #(.OPP_W(W)) dut (
      .clk         (clk),
      .aresetn     (aresetn),
      .in_valid    (inValid),
      .dividend    (dividendIn),
      .divisor     (divisorIn),
      .out_valid   (outValid),
      .quotient    (quotientOut),
      .remainder   (remainderOut),
      .div_by_zero (divByZero),
      .overflow    (overflowOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      nChecks++;
      if (actual == expected)
         nPass++;
      else
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at edge %0d",
                  name, actual, actual, expected, expected, cyc);
   endtask

   // Reference: plain signed integer arithmetic with the two special cases.
   function automatic expT refModel(input int a, input int b);
      expT e;
      int  qi, ri;
      int  minVal = -(1 << (W - 1));
      e.dz = 1'b0;
      e.ov = 1'b0;
      if (b == 0) begin
         qi   = -1;
         ri   = a;
         e.dz = 1'b1;
      end else if (a == minVal && b == -1) begin
         qi   = minVal;
         ri   = 0;
         e.ov = 1'b1;
      end else begin
         qi = a / b;
         ri = a % b;
      end
      e.q = qi[W-1:0];
      e.r = ri[W-1:0];
      e.a = a;
      e.b = b;
      e.edgeN = 0;
      return e;
   endfunction

   task automatic applyStimulus(input int a, input int b, input bit v);
      expT e;
      logic [W-1:0] av, bv;
      av = a[W-1:0];
      bv = b[W-1:0];
      @(negedge clk);
      inValid    = v;
      dividendIn = av;
      divisorIn  = bv;
      if (v) begin
         e = refModel($signed(av), $signed(bv));
         e.edgeN = cyc + 1 + LAT;
         sb.push_back(e);
      end
   endtask

   // Monitor: every presented result must match the oldest outstanding expectation.
   initial begin
      expT e;
      forever begin
         @(negedge clk);
         if (aresetn === 1'b1 && outValid === 1'b1) begin
            if (sb.size() == 0) begin
               checkOutput("spurious_out_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               checkOutput($sformatf("q %0d/%0d", e.a, e.b), quotientOut, e.q);
               checkOutput($sformatf("r %0d/%0d", e.a, e.b), remainderOut, e.r);
               checkOutput($sformatf("dz %0d/%0d", e.a, e.b), divByZero, e.dz);
               checkOutput($sformatf("ov %0d/%0d", e.a, e.b), overflowOut, e.ov);
               checkOutput($sformatf("latency_edge %0d/%0d", e.a, e.b), cyc, e.edgeN);
            end
         end
      end
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_out_valid"}, outValid, 0);
      checkOutput({tag, "_quotient"}, quotientOut, 0);
      checkOutput({tag, "_remainder"}, remainderOut, 0);
      checkOutput({tag, "_div_by_zero"}, divByZero, 0);
      checkOutput({tag, "_overflow"}, overflowOut, 0);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_outstanding", sb.size(), 0);
   endtask

   initial begin
      int a, b;
      aresetn    = 1'b0;
      inValid    = 1'b0;
      dividendIn = '0;
      divisorIn  = '0;
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      @(negedge clk);
      aresetn = 1'b1;

      $display("[TB] sign quadrants and boundaries");
      applyStimulus(100, 7, 1);
      applyStimulus(-100, 7, 1);
      applyStimulus(100, -7, 1);
      applyStimulus(-100, -7, 1);
      applyStimulus(5, 0, 1);
      applyStimulus(-128, -1, 1);
      applyStimulus(-128, 1, 1);
      applyStimulus(0, -3, 1);
      applyStimulus(-5, 0, 1);
      applyStimulus(127, -128, 1);
      applyStimulus(-128, -128, 1);
      applyStimulus(0, 0, 1);
      applyStimulus(0, 0, 0);
      drain(40);

      $display("[TB] streaming random");
      for (int i = 0; i < 500; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) - 2 : $urandom;
         if ($urandom_range(0, 15) == 0) a = -128;
         applyStimulus(a, b, 1);
      end
      applyStimulus(0, 0, 0);
      drain(40);

      $display("[TB] bubbles");
      for (int i = 0; i < 12; i++)
         applyStimulus($urandom, $urandom_range(1, 60), (i % 3) == 0);
      applyStimulus(0, 0, 0);
      drain(40);

      $display("[TB] reset mid-flight");
      for (int i = 0; i < 4; i++)
         applyStimulus(-77 + 13 * i, 3 + i, 1);
      applyStimulus(0, 0, 0);
      @(posedge clk);
      #2;
      sb.delete();
      aresetn = 1'b0;
      #1;
      checkAllZero("midreset");
      @(posedge clk);
      #2;
      aresetn = 1'b1;
      repeat (LAT + 6) @(negedge clk);
      checkOutput("post_reset_idle_out_valid", outValid, 0);
      applyStimulus(-100, 7, 1);
      applyStimulus(0, 0, 0);
      drain(40);

      $display("[TB] %0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
